// File: rtl/std_cache_pkg.sv
// -----------------------------------------------------------------------------
// std_cache_pkg
// Shared types for the cache subsystem memory port and the outstanding
// transaction tracker:
//   - CntWidth / NumCls / WPendWidth : tracker counter geometry
//   - cls_e / cls_decode()           : source class taken from ID bits [3:2]
//   - trk_state_e                    : tracker quiesce FSM states
//   - cache_axi_req_t / _rsp_t       : AXI (with ACE snoop channels) port types
// -----------------------------------------------------------------------------
package std_cache_pkg;

  localparam int unsigned CntWidth   = 4;
  localparam int unsigned NumCls     = 3;
  // Holds up to NumCls * 15 AW beats that are still waiting for their W data.
  localparam int unsigned WPendWidth = 6;

  typedef enum logic [1:0] {
    CLS_DCACHE = 2'd0,
    CLS_BYPASS = 2'd1,
    CLS_ICACHE = 2'd2
  } cls_e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } trk_state_e;

  // Both 2'b00 and 2'b01 belong to the instruction cache.
  function automatic cls_e cls_decode(input logic [1:0] id_cls);
    cls_e cls;
    case (id_cls)
      2'b11:   cls = CLS_DCACHE;
      2'b10:   cls = CLS_BYPASS;
      default: cls = CLS_ICACHE;
    endcase
    return cls;
  endfunction

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ax_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  snoop;
  } ac_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } cd_chan_t;

  typedef struct packed {
    ax_chan_t   aw;
    logic       aw_valid;
    w_chan_t    w;
    logic       w_valid;
    logic       b_ready;
    ax_chan_t   ar;
    logic       ar_valid;
    logic       r_ready;
    logic       ac_ready;
    logic       cr_valid;
    logic [4:0] cr_resp;
    logic       cd_valid;
    cd_chan_t   cd;
  } cache_axi_req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     ar_ready;
    logic     w_ready;
    logic     b_valid;
    b_chan_t  b;
    logic     r_valid;
    r_chan_t  r;
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } cache_axi_rsp_t;

endpackage

// File: rtl/axi_tracker_class_cnt.sv
// -----------------------------------------------------------------------------
// axi_tracker_class_cnt
// Up/down counter of outstanding transactions for one class and one direction.
// Saturates at all-ones and never wraps below zero.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   inc_i, dec_i  : transaction issued / completed this cycle
//   cnt_o         : registered count
//   at_max_o      : count equals MaxOutstanding
//   underflow_o   : completion seen while nothing is outstanding (this cycle)
// -----------------------------------------------------------------------------
module axi_tracker_class_cnt
  import std_cache_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                at_max_o,
  output logic                underflow_o
);

  localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(MaxOutstanding);
  localparam logic [CntWidth-1:0] SatCnt  = {CntWidth{1'b1}};
  localparam logic [CntWidth-1:0] ZeroCnt = {CntWidth{1'b0}};

  logic [CntWidth-1:0] r_cnt;

  // Count update; a simultaneous increment and decrement cancel out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= ZeroCnt;
    end else begin
      case ({inc_i, dec_i})
        2'b10: begin
          if (r_cnt != SatCnt) r_cnt <= r_cnt + CntWidth'(1'b1);
          else                 r_cnt <= r_cnt;
        end
        2'b01: begin
          if (r_cnt != ZeroCnt) r_cnt <= r_cnt - CntWidth'(1'b1);
          else                  r_cnt <= r_cnt;
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign cnt_o       = r_cnt;
  assign at_max_o    = (r_cnt == MaxCnt);
  assign underflow_o = dec_i & ~inc_i & (r_cnt == ZeroCnt);

endmodule

// File: rtl/axi_outstanding_tracker.sv
// -----------------------------------------------------------------------------
// axi_outstanding_tracker
// Sits between the cache subsystem memory port and the interconnect. Counts
// outstanding reads and writes per source class (dcache / bypass / icache),
// throttles AR and AW when a class hits its limit, and can quiesce the port.
// Every channel passes through combinationally; only ar/aw valid/ready are
// gated.
//   clk_i, rst_i : clock, synchronous active-high reset
//   slv_req_i    : request from the cache subsystem
//   slv_resp_o   : response to the cache subsystem
//   mst_req_o    : request to the interconnect
//   mst_resp_i   : response from the interconnect
//   drain_i      : level request to stop issuing and wait for idle
//   drained_o    : port idle and no new AR/AW accepted
//   rd_cnt_o     : outstanding reads  [0] dcache, [1] bypass, [2] icache
//   wr_cnt_o     : outstanding writes, same indexing
//   err_o        : sticky error (counter / W-pending underflow, watchdog)
// Optional build macro: AXI_TRACKER_WATCHDOG_EN adds a no-progress watchdog
// that raises err_o after TimeoutCycles cycles without R-last or B.
// -----------------------------------------------------------------------------
module axi_outstanding_tracker
  import std_cache_pkg::*;
#(
  parameter int unsigned AxiIdWidth     = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned TimeoutCycles  = 1024,
  parameter type         axi_req_t      = cache_axi_req_t,
  parameter type         axi_rsp_t      = cache_axi_rsp_t
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  axi_req_t                        slv_req_i,
  output axi_rsp_t                        slv_resp_o,
  output axi_req_t                        mst_req_o,
  input  axi_rsp_t                        mst_resp_i,
  input  logic                            drain_i,
  output logic                            drained_o,
  output logic [NumCls-1:0][CntWidth-1:0] rd_cnt_o,
  output logic [NumCls-1:0][CntWidth-1:0] wr_cnt_o,
  output logic                            err_o
);

  trk_state_e            r_state;
  logic                  r_drained;
  logic                  r_err;
  logic                  r_ar_hold;
  logic                  r_aw_hold;
  logic [WPendWidth-1:0] r_wpend;

  cls_e              w_ar_cls, w_aw_cls, w_r_cls, w_b_cls;
  logic [NumCls-1:0] w_rd_inc, w_rd_dec, w_rd_at_max, w_rd_uf;
  logic [NumCls-1:0] w_wr_inc, w_wr_dec, w_wr_at_max, w_wr_uf;
  logic              w_ar_block, w_aw_block;
  logic              w_mst_ar_valid, w_mst_aw_valid;
  logic              w_ar_hs, w_aw_hs, w_r_last_hs, w_b_hs, w_w_last_hs;
  logic              w_wp_uf, w_all_zero, w_idle, w_wd_hit;

  // The class bits are the top two bits of the ID ([3:2] for a 4-bit ID).
  assign w_ar_cls = cls_decode(slv_req_i.ar.id[AxiIdWidth-1 -: 2]);
  assign w_aw_cls = cls_decode(slv_req_i.aw.id[AxiIdWidth-1 -: 2]);
  assign w_r_cls  = cls_decode(mst_resp_i.r.id[AxiIdWidth-1 -: 2]);
  assign w_b_cls  = cls_decode(mst_resp_i.b.id[AxiIdWidth-1 -: 2]);

  // A hold flop overrides the block so a presented valid is never withdrawn.
  assign w_ar_block = ~r_ar_hold & (w_rd_at_max[w_ar_cls] | (r_state != ST_RUN));
  assign w_aw_block = ~r_aw_hold & (w_wr_at_max[w_aw_cls] | (r_state != ST_RUN));

  assign w_mst_ar_valid = slv_req_i.ar_valid & ~w_ar_block;
  assign w_mst_aw_valid = slv_req_i.aw_valid & ~w_aw_block;

  assign w_ar_hs     = w_mst_ar_valid & mst_resp_i.ar_ready;
  assign w_aw_hs     = w_mst_aw_valid & mst_resp_i.aw_ready;
  assign w_r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
  assign w_b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;
  assign w_w_last_hs = slv_req_i.w_valid & mst_resp_i.w_ready & slv_req_i.w.last;

  // Pass-through with only the AR/AW handshake gated.
  always_comb begin
    mst_req_o           = slv_req_i;
    mst_req_o.ar_valid  = w_mst_ar_valid;
    mst_req_o.aw_valid  = w_mst_aw_valid;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ~w_ar_block;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & ~w_aw_block;
  end

  for (genvar g = 0; g < NumCls; g++) begin : g_cls
    assign w_rd_inc[g] = w_ar_hs     & (w_ar_cls == cls_e'(g));
    assign w_rd_dec[g] = w_r_last_hs & (w_r_cls  == cls_e'(g));
    assign w_wr_inc[g] = w_aw_hs     & (w_aw_cls == cls_e'(g));
    assign w_wr_dec[g] = w_b_hs      & (w_b_cls  == cls_e'(g));

    axi_tracker_class_cnt #(
      .MaxOutstanding(MaxOutstanding)
    ) u_rd_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .inc_i      (w_rd_inc[g]),
      .dec_i      (w_rd_dec[g]),
      .cnt_o      (rd_cnt_o[g]),
      .at_max_o   (w_rd_at_max[g]),
      .underflow_o(w_rd_uf[g])
    );

    axi_tracker_class_cnt #(
      .MaxOutstanding(MaxOutstanding)
    ) u_wr_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .inc_i      (w_wr_inc[g]),
      .dec_i      (w_wr_dec[g]),
      .cnt_o      (wr_cnt_o[g]),
      .at_max_o   (w_wr_at_max[g]),
      .underflow_o(w_wr_uf[g])
    );
  end

  // Hold flops: set while a valid sits downstream without ready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ar_hold <= 1'b0;
      r_aw_hold <= 1'b0;
    end else begin
      r_ar_hold <= w_mst_ar_valid & ~mst_resp_i.ar_ready;
      r_aw_hold <= w_mst_aw_valid & ~mst_resp_i.aw_ready;
    end
  end

  assign w_wp_uf = w_w_last_hs & ~w_aw_hs & (r_wpend == {WPendWidth{1'b0}});

  // AW beats still waiting for their final W beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wpend <= {WPendWidth{1'b0}};
    end else begin
      case ({w_aw_hs, w_w_last_hs})
        2'b10: r_wpend <= r_wpend + WPendWidth'(1'b1);
        2'b01: begin
          if (r_wpend != {WPendWidth{1'b0}}) r_wpend <= r_wpend - WPendWidth'(1'b1);
          else                               r_wpend <= r_wpend;
        end
        default: r_wpend <= r_wpend;
      endcase
    end
  end

  assign w_all_zero = ~|{rd_cnt_o, wr_cnt_o};
  assign w_idle     = w_all_zero & ~r_ar_hold & ~r_aw_hold &
                      (r_wpend == {WPendWidth{1'b0}});

`ifdef AXI_TRACKER_WATCHDOG_EN
  localparam int unsigned WdWidth = $clog2(TimeoutCycles + 1);

  logic [WdWidth-1:0] r_wd_cnt;

  // No-progress counter: restarts on any completion or when nothing is open.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wd_cnt <= {WdWidth{1'b0}};
    end else if (w_r_last_hs | w_b_hs | w_all_zero) begin
      r_wd_cnt <= {WdWidth{1'b0}};
    end else if (r_wd_cnt != WdWidth'(TimeoutCycles)) begin
      r_wd_cnt <= r_wd_cnt + WdWidth'(1'b1);
    end else begin
      r_wd_cnt <= r_wd_cnt;
    end
  end

  assign w_wd_hit = (r_wd_cnt == WdWidth'(TimeoutCycles));
`else
  assign w_wd_hit = 1'b0;
`endif

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if ((|w_rd_uf) | (|w_wr_uf) | w_wp_uf | w_wd_hit) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  // Quiesce FSM with registered drained flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_RUN;
      r_drained <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_drained <= 1'b0;
          if (drain_i) r_state <= ST_DRAIN;
          else         r_state <= ST_RUN;
        end
        ST_DRAIN: begin
          if (!drain_i) begin
            r_state   <= ST_RUN;
            r_drained <= 1'b0;
          end else if (w_idle) begin
            r_state   <= ST_DRAINED;
            r_drained <= 1'b1;
          end else begin
            r_state   <= ST_DRAIN;
            r_drained <= 1'b0;
          end
        end
        ST_DRAINED: begin
          if (!drain_i) begin
            r_state   <= ST_RUN;
            r_drained <= 1'b0;
          end else begin
            r_state   <= ST_DRAINED;
            r_drained <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_RUN;
          r_drained <= 1'b0;
        end
      endcase
    end
  end

  assign drained_o = r_drained;
  assign err_o     = r_err;

endmodule

// File: tb/tb_axi_outstanding_tracker.sv
// -----------------------------------------------------------------------------
// tb_axi_outstanding_tracker
// Randomized traffic against a per-class outstanding-count model, followed by
// directed limit / simultaneous / drain / hold / underflow / watchdog cases.
// -----------------------------------------------------------------------------
module tb_axi_outstanding_tracker;
  import std_cache_pkg::*;

  localparam int unsigned MAXO    = 4;
  localparam int unsigned TIMEOUT = 16;

  logic           clk;
  logic           rst;
  cache_axi_req_t slv_req, mst_req;
  cache_axi_rsp_t slv_rsp, mst_rsp;
  logic           drain, drained, err;
  logic [2:0][3:0] rd_cnt, wr_cnt;

  int n_checks;
  int n_fail;

  // Reference model: plain outstanding counts and "valid shown downstream".
  int m_rd[3];
  int m_wr[3];
  int m_wpend;
  bit m_ar_down, m_aw_down;
  bit ar_stall, aw_stall;
  int c, ci, cw;
  bit exp_blk, hs;
  bit got;

  axi_outstanding_tracker #(
    .AxiIdWidth    (4),
    .MaxOutstanding(MAXO),
    .TimeoutCycles (TIMEOUT),
    .axi_req_t     (cache_axi_req_t),
    .axi_rsp_t     (cache_axi_rsp_t)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .slv_req_i (slv_req),
    .slv_resp_o(slv_rsp),
    .mst_req_o (mst_req),
    .mst_resp_i(mst_rsp),
    .drain_i   (drain),
    .drained_o (drained),
    .rd_cnt_o  (rd_cnt),
    .wr_cnt_o  (wr_cnt),
    .err_o     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Class by the spec table: 11 dcache, 10 bypass, 0x icache.
  function automatic int cls_of(input logic [3:0] id);
    if (id[3] == 1'b1 && id[2] == 1'b1) return 0;
    else if (id[3] == 1'b1)             return 1;
    else                                return 2;
  endfunction

  function automatic logic [3:0] id_for(input int cl);
    logic [3:0] r;
    r = 4'($urandom_range(0, 15));
    if (cl == 0)      r[3:2] = 2'b11;
    else if (cl == 1) r[3:2] = 2'b10;
    else              r[3]   = 1'b0;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst     = 1'b1;
    slv_req = '0;
    mst_rsp = '0;
    drain   = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_rd[k] = 0;
      m_wr[k] = 0;
    end
    m_wpend   = 0;
    m_ar_down = 1'b0;
    m_aw_down = 1'b0;
    ar_stall  = 1'b0;
    aw_stall  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_dut();
    #1;
    for (int k = 0; k < 3; k++) begin
      check_val("rst_rd_cnt", 32'(rd_cnt[k]), 32'd0);
      check_val("rst_wr_cnt", 32'(wr_cnt[k]), 32'd0);
    end
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_drained", 32'(drained), 32'd0);

    // ---------------- randomized traffic ----------------
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        check_val("rnd_rd_cnt", 32'(rd_cnt[k]), 32'(m_rd[k]));
        check_val("rnd_wr_cnt", 32'(wr_cnt[k]), 32'(m_wr[k]));
      end
      check_val("rnd_err", 32'(err), 32'd0);
      check_val("rnd_drained", 32'(drained), 32'd0);

      if (!ar_stall) begin
        slv_req.ar_valid = ($urandom_range(0, 3) != 0);
        slv_req.ar.id    = id_for($urandom_range(0, 2));
        slv_req.ar.addr  = $urandom;
      end
      if (!aw_stall) begin
        slv_req.aw_valid = ($urandom_range(0, 3) != 0);
        slv_req.aw.id    = id_for($urandom_range(0, 2));
        slv_req.aw.addr  = $urandom;
      end
      mst_rsp.ar_ready = 1'($urandom_range(0, 1));
      mst_rsp.aw_ready = 1'($urandom_range(0, 1));

      slv_req.w_valid  = (m_wpend > 0) && ($urandom_range(0, 1) == 1);
      slv_req.w.last   = 1'($urandom_range(0, 1));
      slv_req.w.data   = $urandom;
      mst_rsp.w_ready  = 1'($urandom_range(0, 1));

      c = $urandom_range(0, 2);
      mst_rsp.r_valid  = (m_rd[c] > 0) && ($urandom_range(0, 3) == 0);
      mst_rsp.r.id     = id_for(c);
      mst_rsp.r.last   = 1'($urandom_range(0, 1));
      mst_rsp.r.data   = $urandom;
      slv_req.r_ready  = 1'($urandom_range(0, 1));

      c = $urandom_range(0, 2);
      mst_rsp.b_valid  = (m_wr[c] > 0) && ($urandom_range(0, 3) == 0);
      mst_rsp.b.id     = id_for(c);
      slv_req.b_ready  = 1'($urandom_range(0, 1));
      #1;

      // AR gating
      ci = cls_of(slv_req.ar.id);
      exp_blk = !m_ar_down && (m_rd[ci] == MAXO);
      check_val("rnd_mst_ar_valid", 32'(mst_req.ar_valid), 32'(slv_req.ar_valid && !exp_blk));
      check_val("rnd_slv_ar_ready", 32'(slv_rsp.ar_ready), 32'(mst_rsp.ar_ready && !exp_blk));
      hs        = slv_req.ar_valid && !exp_blk && mst_rsp.ar_ready;
      m_ar_down = slv_req.ar_valid && !exp_blk && !mst_rsp.ar_ready;
      ar_stall  = slv_req.ar_valid && !hs;
      if (hs) m_rd[ci]++;

      // AW gating
      cw = cls_of(slv_req.aw.id);
      exp_blk = !m_aw_down && (m_wr[cw] == MAXO);
      check_val("rnd_mst_aw_valid", 32'(mst_req.aw_valid), 32'(slv_req.aw_valid && !exp_blk));
      check_val("rnd_slv_aw_ready", 32'(slv_rsp.aw_ready), 32'(mst_rsp.aw_ready && !exp_blk));
      hs        = slv_req.aw_valid && !exp_blk && mst_rsp.aw_ready;
      m_aw_down = slv_req.aw_valid && !exp_blk && !mst_rsp.aw_ready;
      aw_stall  = slv_req.aw_valid && !hs;
      if (hs) begin
        m_wr[cw]++;
        m_wpend++;
      end

      check_val("rnd_ar_addr", mst_req.ar.addr, slv_req.ar.addr);
      check_val("rnd_w_data", mst_req.w.data, slv_req.w.data);
      check_val("rnd_r_data", slv_rsp.r.data, mst_rsp.r.data);

      if (mst_rsp.r_valid && slv_req.r_ready && mst_rsp.r.last) m_rd[cls_of(mst_rsp.r.id)]--;
      if (mst_rsp.b_valid && slv_req.b_ready) m_wr[cls_of(mst_rsp.b.id)]--;
      if (slv_req.w_valid && mst_rsp.w_ready && slv_req.w.last) m_wpend--;
    end

    // ---------------- limit: 5 dcache ARs, limit 4 ----------------
    reset_dut();
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = 4'b1100;
    mst_rsp.ar_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_val("lim_accept", 32'(slv_rsp.ar_ready), 32'd1);
      tick();
    end
    check_val("lim_cnt4", 32'(rd_cnt[0]), 32'd4);
    check_val("lim_blk_ready", 32'(slv_rsp.ar_ready), 32'd0);
    check_val("lim_blk_valid", 32'(mst_req.ar_valid), 32'd0);
    mst_rsp.r_valid  = 1'b1;
    mst_rsp.r.id     = 4'b1100;
    mst_rsp.r.last   = 1'b1;
    slv_req.r_ready  = 1'b1;
    #1;
    check_val("lim_blk_during_r", 32'(slv_rsp.ar_ready), 32'd0);
    tick();
    mst_rsp.r_valid = 1'b0;
    #1;
    check_val("lim_cnt3", 32'(rd_cnt[0]), 32'd3);
    check_val("lim_5th_accept", 32'(slv_rsp.ar_ready), 32'd1);
    tick();
    slv_req.ar_valid = 1'b0;
    check_val("lim_cnt4_again", 32'(rd_cnt[0]), 32'd4);

    // ---------------- simultaneous inc/dec on bypass ----------------
    reset_dut();
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = 4'b1000;
    mst_rsp.ar_ready = 1'b1;
    repeat (2) tick();
    check_val("sim_cnt2", 32'(rd_cnt[1]), 32'd2);
    mst_rsp.r_valid  = 1'b1;
    mst_rsp.r.id     = 4'b1000;
    mst_rsp.r.last   = 1'b1;
    slv_req.r_ready  = 1'b1;
    tick();
    slv_req.ar_valid = 1'b0;
    mst_rsp.r_valid  = 1'b0;
    check_val("sim_cnt_stays2", 32'(rd_cnt[1]), 32'd2);
    check_val("sim_err", 32'(err), 32'd0);

    // ---------------- drain with one write outstanding ----------------
    reset_dut();
    slv_req.aw_valid = 1'b1;
    slv_req.aw.id    = 4'b0000;
    mst_rsp.aw_ready = 1'b1;
    tick();
    slv_req.aw_valid = 1'b0;
    slv_req.w_valid  = 1'b1;
    slv_req.w.last   = 1'b1;
    mst_rsp.w_ready  = 1'b1;
    tick();
    slv_req.w_valid  = 1'b0;
    check_val("drn_wr_cnt1", 32'(wr_cnt[2]), 32'd1);
    drain = 1'b1;
    tick();
    slv_req.aw_valid = 1'b1;
    #1;
    check_val("drn_aw_blk_ready", 32'(slv_rsp.aw_ready), 32'd0);
    check_val("drn_aw_blk_valid", 32'(mst_req.aw_valid), 32'd0);
    tick();
    check_val("drn_not_yet", 32'(drained), 32'd0);
    mst_rsp.b_valid = 1'b1;
    mst_rsp.b.id    = 4'b0000;
    slv_req.b_ready = 1'b1;
    tick();
    mst_rsp.b_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      if (drained) got = 1'b1;
      else         tick();
    end
    check_val("drn_drained", 32'(drained), 32'd1);
    check_val("drn_still_blk", 32'(slv_rsp.aw_ready), 32'd0);
    drain = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      #1;
      if (slv_rsp.aw_ready) got = 1'b1;
      else                  tick();
    end
    check_val("drn_aw_resume", 32'(slv_rsp.aw_ready), 32'd1);
    tick();
    slv_req.aw_valid = 1'b0;
    check_val("drn_wr_cnt_after", 32'(wr_cnt[2]), 32'd1);
    check_val("drn_drained_low", 32'(drained), 32'd0);

    // ---------------- hold: stalled AR survives drain ----------------
    reset_dut();
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = 4'b0100;
    mst_rsp.ar_ready = 1'b0;
    #1;
    check_val("hold_initial", 32'(mst_req.ar_valid), 32'd1);
    tick();
    drain = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val("hold_valid_kept", 32'(mst_req.ar_valid), 32'd1);
    end
    mst_rsp.ar_ready = 1'b1;
    #1;
    check_val("hold_hs_ready", 32'(slv_rsp.ar_ready), 32'd1);
    tick();
    slv_req.ar.id = 4'b0001;
    #1;
    check_val("hold_then_blk", 32'(mst_req.ar_valid), 32'd0);
    check_val("hold_then_blk_rdy", 32'(slv_rsp.ar_ready), 32'd0);
    check_val("hold_cnt", 32'(rd_cnt[2]), 32'd1);
    slv_req.ar_valid = 1'b0;
    drain = 1'b0;

    // ---------------- underflow on B and on W ----------------
    reset_dut();
    mst_rsp.b_valid = 1'b1;
    mst_rsp.b.id    = 4'b0000;
    slv_req.b_ready = 1'b1;
    #1;
    check_val("uf_err_before", 32'(err), 32'd0);
    tick();
    mst_rsp.b_valid = 1'b0;
    check_val("uf_err_set", 32'(err), 32'd1);
    check_val("uf_cnt_zero", 32'(wr_cnt[2]), 32'd0);
    repeat (5) tick();
    check_val("uf_err_sticky", 32'(err), 32'd1);
    reset_dut();
    check_val("uf_err_cleared", 32'(err), 32'd0);
    slv_req.w_valid = 1'b1;
    slv_req.w.last  = 1'b1;
    mst_rsp.w_ready = 1'b1;
    tick();
    slv_req.w_valid = 1'b0;
    check_val("uf_w_err", 32'(err), 32'd1);

    // ---------------- watchdog: one read, no R ----------------
    reset_dut();
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = 4'b0000;
    mst_rsp.ar_ready = 1'b1;
    tick();
    slv_req.ar_valid = 1'b0;
    repeat (8) tick();
    check_val("wd_early", 32'(err), 32'd0);
    repeat (16) tick();
`ifdef AXI_TRACKER_WATCHDOG_EN
    check_val("wd_timeout", 32'(err), 32'd1);
`else
    check_val("wd_absent", 32'(err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
